// File: rtl/pixel_pkg.sv
// pixel_pkg: shared pixel types for the RGB16 ingest path.
//   rgb24_t     - packed {R,G,B} bytes
//   pix_entry_t - one buffered pixel: colour, coordinates and frame flags
//   expand565   - widens zero-padded 5/6/5-bit channels to full 8-bit range
package pixel_pkg;

   // Coordinates are stored at a fixed width so the entry type does not
   // depend on the frame geometry; users keep X_W/Y_W <= COORD_W.
   localparam int COORD_W = 16;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb24_t;

   typedef struct packed {
      rgb24_t             rgb;
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic               sof;
      logic               eol;
      logic               eof;
   } pix_entry_t;

   // MSB replication maps full-scale 5/6-bit codes to 0xFF and zero to 0x00.
   function automatic rgb24_t expand565(input rgb24_t c);
      rgb24_t e;
      e.r = {c.r[7:3], c.r[7:5]};
      e.g = {c.g[7:2], c.g[7:6]};
      e.b = {c.b[7:3], c.b[7:5]};
      return e;
   endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock first-word-fall-through FIFO.
//   push/din/full  - write side; a push into a full FIFO is accepted only
//                    when a pop happens in the same cycle
//   pop/dout/empty - read side; dout shows the head entry whenever !empty
//   level          - registered occupancy, equals DEPTH when full
module sync_fifo_fwft #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     push,
   input  logic [W-1:0]             din,
   output logic                     full,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   // Extra MSB on each pointer separates full from empty at equal addresses.
   logic [AW:0]  wr_ptr, rd_ptr;
   logic         do_push, do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge i_clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   level <= level + 1'b1;
            2'b01:   level <= level - 1'b1;
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/rgb_pixel_framer.sv
// rgb_pixel_framer: tags parser pixels with frame coordinates/flags, optionally
// expands RGB565 channels to 8 bits, and buffers them towards the dehazer.
//   i_valid, i_channel_R/G/B - pixel strobe from the parser (no back-pressure)
//   i_sync                   - restart geometry; next pixel is (0,0)
//   i_clr_ovf                - clears the sticky o_overflow
//   o_valid/i_ready          - FWFT output handshake
//   o_data,o_x,o_y,o_sof,o_eol,o_eof - head pixel (all zero while empty)
//   o_overflow, o_frame_cnt, o_level - status
module rgb_pixel_framer
   import pixel_pkg::*;
#(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480,
   parameter int X_W    = 11,
   parameter int Y_W    = 10,
   parameter int DEPTH  = 16,
   parameter int EXPAND = 1
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_sync,
   input  logic                       i_clr_ovf,
   input  logic                       i_valid,
   input  logic [7:0]                 i_channel_R,
   input  logic [7:0]                 i_channel_G,
   input  logic [7:0]                 i_channel_B,
   output logic                       o_valid,
   input  logic                       i_ready,
   output logic [23:0]                o_data,
   output logic [X_W-1:0]             o_x,
   output logic [Y_W-1:0]             o_y,
   output logic                       o_sof,
   output logic                       o_eol,
   output logic                       o_eof,
   output logic                       o_overflow,
   output logic [7:0]                 o_frame_cnt,
   output logic [$clog2(DEPTH):0]     o_level
);

   logic [X_W-1:0] x_q, tag_x;
   logic [Y_W-1:0] y_q, tag_y;
   logic           x_last, y_last;
   logic           full, empty, drop;
   rgb24_t         rgb_in, rgb_px;
   pix_entry_t     entry, head;

   // A sync arriving with a pixel retags that pixel as the frame origin.
   assign tag_x  = i_sync ? '0 : x_q;
   assign tag_y  = i_sync ? '0 : y_q;
   assign x_last = (tag_x == X_W'(WIDTH - 1));
   assign y_last = (tag_y == Y_W'(HEIGHT - 1));

   assign rgb_in = '{r: i_channel_R, g: i_channel_G, b: i_channel_B};
   assign rgb_px = (EXPAND != 0) ? expand565(rgb_in) : rgb_in;

   always_comb begin
      entry     = '0;
      entry.rgb = rgb_px;
      entry.x   = COORD_W'(tag_x);
      entry.y   = COORD_W'(tag_y);
      entry.sof = (tag_x == '0) && (tag_y == '0);
      entry.eol = x_last;
      entry.eof = x_last && y_last;
   end

   // Geometry advances on every strobe, dropped or not, so later pixels keep
   // their true positions after an overflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         x_q         <= '0;
         y_q         <= '0;
         o_frame_cnt <= '0;
      end else if (i_valid) begin
         if (!x_last) begin
            x_q <= tag_x + 1'b1;
            y_q <= tag_y;
         end else begin
            x_q <= '0;
            if (y_last) begin
               y_q         <= '0;
               o_frame_cnt <= o_frame_cnt + 1'b1;
            end else begin
               y_q <= tag_y + 1'b1;
            end
         end
      end else if (i_sync) begin
         x_q <= '0;
         y_q <= '0;
      end
   end

   // Full implies non-empty, so a ready downstream always frees a slot.
   assign drop = i_valid && full && !i_ready;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)       o_overflow <= 1'b0;
      else if (drop)      o_overflow <= 1'b1;
      else if (i_clr_ovf) o_overflow <= 1'b0;
   end

   sync_fifo_fwft #(
      .W     ($bits(pix_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .push    (i_valid),
      .din     (entry),
      .full    (full),
      .pop     (i_ready),
      .dout    (head),
      .empty   (empty),
      .level   (o_level)
   );

   // Storage is not reset; mask the head so outputs read zero while empty.
   assign o_valid = !empty;
   assign o_data  = empty ? '0 : head.rgb;
   assign o_x     = empty ? '0 : head.x[X_W-1:0];
   assign o_y     = empty ? '0 : head.y[Y_W-1:0];
   assign o_sof   = !empty && head.sof;
   assign o_eol   = !empty && head.eol;
   assign o_eof   = !empty && head.eof;

   logic unused_coord_bits;
   assign unused_coord_bits = ^{head.x, head.y};

endmodule

// File: tb/tb_rgb_pixel_framer.sv
module tb_rgb_pixel_framer;

   localparam int WIDTH  = 24;
   localparam int HEIGHT = 2;
   localparam int X_W    = 5;
   localparam int Y_W    = 2;
   localparam int DEPTH  = 16;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic           i_clk = 1'b0;
   logic           i_rst_n = 1'b0;
   logic           i_sync = 1'b0;
   logic           i_clr_ovf = 1'b0;
   logic           i_valid = 1'b0;
   logic [7:0]     i_channel_R = '0;
   logic [7:0]     i_channel_G = '0;
   logic [7:0]     i_channel_B = '0;
   logic           o_valid;
   logic           i_ready = 1'b0;
   logic [23:0]    o_data;
   logic [X_W-1:0] o_x;
   logic [Y_W-1:0] o_y;
   logic           o_sof, o_eol, o_eof, o_overflow;
   logic [7:0]     o_frame_cnt;
   logic [LW-1:0]  o_level;

   int n_cmp = 0;
   int n_bad = 0;

   rgb_pixel_framer #(
      .WIDTH(WIDTH), .HEIGHT(HEIGHT), .X_W(X_W), .Y_W(Y_W), .DEPTH(DEPTH), .EXPAND(1)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_sync(i_sync), .i_clr_ovf(i_clr_ovf),
      .i_valid(i_valid), .i_channel_R(i_channel_R), .i_channel_G(i_channel_G),
      .i_channel_B(i_channel_B), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_x(o_x), .o_y(o_y), .o_sof(o_sof), .o_eol(o_eol),
      .o_eof(o_eof), .o_overflow(o_overflow), .o_frame_cnt(o_frame_cnt),
      .o_level(o_level)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the edge; outputs are read there too.
   task automatic step();
      @(posedge i_clk);
      #1;
   endtask

   task automatic push(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      i_valid     = 1'b1;
      i_channel_R = r;
      i_channel_G = g;
      i_channel_B = b;
      step();
      i_valid = 1'b0;
   endtask

   task automatic sync_pulse();
      i_sync = 1'b1;
      step();
      i_sync = 1'b0;
   endtask

   initial begin
      logic [4:0] r5;
      repeat (2) step();
      chk("rst_valid", o_valid, 0);
      chk("rst_level", o_level, 0);
      chk("rst_ovf",   o_overflow, 0);
      chk("rst_fcnt",  o_frame_cnt, 0);
      chk("rst_data",  o_data, 0);
      i_rst_n = 1'b1;
      step();

      // first pixel latency and full-scale expansion
      i_ready = 1'b1;
      push(8'hF8, 8'hFC, 8'hF8);
      chk("p0_valid", o_valid, 1);
      chk("p0_data",  o_data, 24'hFFFFFF);
      chk("p0_x",     o_x, 0);
      chk("p0_y",     o_y, 0);
      chk("p0_sof",   o_sof, 1);
      chk("p0_level", o_level, 1);
      push(8'h80, 8'h04, 8'h08);
      chk("p1_data",  o_data, 24'h840408);
      chk("p1_x",     o_x, 1);
      chk("p1_sof",   o_sof, 0);
      step();
      chk("p1_level", o_level, 0);
      chk("p1_valid", o_valid, 0);

      // one full frame at sustained rate
      sync_pulse();
      for (int i = 0; i < WIDTH * HEIGHT; i++) begin
         push(8'((i * 8) & 8'hF8), 8'h00, 8'hF8);
         r5 = 5'(i % 32);
         chk("fr_x",   o_x, i % WIDTH);
         chk("fr_y",   o_y, i / WIDTH);
         chk("fr_eol", o_eol, (i % WIDTH) == WIDTH - 1);
         chk("fr_eof", o_eof, i == WIDTH * HEIGHT - 1);
         chk("fr_r",   o_data[23:16], {r5, r5[4:2]});
      end
      chk("fr_fcnt", o_frame_cnt, 1);
      push(8'h00, 8'h00, 8'h00);
      chk("fr2_sof", o_sof, 1);
      chk("fr2_x",   o_x, 0);
      chk("fr2_y",   o_y, 0);
      step();
      chk("fr_drain", o_level, 0);

      // overflow: 20 pushes into 16 slots, geometry preserved
      sync_pulse();
      i_ready = 1'b0;
      repeat (20) push(8'h10, 8'h20, 8'h30);
      chk("ov_level", o_level, 16);
      chk("ov_flag",  o_overflow, 1);
      i_ready = 1'b1;
      for (int k = 0; k < 16; k++) begin
         chk("ov_valid", o_valid, 1);
         chk("ov_x", o_x, k);
         step();
      end
      chk("ov_empty", o_valid, 0);
      chk("ov_lvl0",  o_level, 0);
      push(8'h00, 8'h00, 8'h00);
      chk("ov_geo_x", o_x, 20);
      chk("ov_geo_y", o_y, 0);
      step();
      chk("ov_fcnt", o_frame_cnt, 1);
      chk("ov_sticky", o_overflow, 1);
      i_clr_ovf = 1'b1;
      step();
      i_clr_ovf = 1'b0;
      chk("ov_clr", o_overflow, 0);

      // sync together with a pixel at x=5
      sync_pulse();
      repeat (5) push(8'h00, 8'h00, 8'h00);
      chk("sy_x4", o_x, 4);
      i_sync = 1'b1;
      push(8'h00, 8'h00, 8'h00);
      i_sync = 1'b0;
      chk("sy_x",   o_x, 0);
      chk("sy_y",   o_y, 0);
      chk("sy_sof", o_sof, 1);
      push(8'h00, 8'h00, 8'h00);
      chk("sy_nx",   o_x, 1);
      chk("sy_nsof", o_sof, 0);
      chk("sy_fcnt", o_frame_cnt, 1);
      step();

      // full FIFO, push and pop in the same cycle
      i_ready = 1'b0;
      repeat (16) push(8'h00, 8'h00, 8'h00);
      chk("fp_level", o_level, 16);
      chk("fp_head",  o_x, 2);
      i_ready = 1'b1;
      push(8'h00, 8'h00, 8'h00);
      i_ready = 1'b0;
      chk("fp_level2", o_level, 16);
      chk("fp_novf",   o_overflow, 0);
      chk("fp_head2",  o_x, 3);
      step();
      chk("fp_hold", o_x, 3);
      chk("fp_hold_lvl", o_level, 16);

      // clear and drop in the same cycle: set wins
      i_clr_ovf = 1'b1;
      push(8'h00, 8'h00, 8'h00);
      i_clr_ovf = 1'b0;
      chk("cd_ovf",   o_overflow, 1);
      chk("cd_level", o_level, 16);

      // reset mid-frame with 7 buffered pixels
      i_ready = 1'b1;
      repeat (16) step();
      chk("rm_drain", o_level, 0);
      i_ready = 1'b0;
      repeat (7) push(8'hF8, 8'hFC, 8'hF8);
      chk("rm_level7", o_level, 7);
      i_rst_n = 1'b0;
      #1;
      chk("rm_valid", o_valid, 0);
      chk("rm_level", o_level, 0);
      chk("rm_data",  o_data, 0);
      chk("rm_x",     o_x, 0);
      chk("rm_ovf",   o_overflow, 0);
      chk("rm_fcnt",  o_frame_cnt, 0);
      step();
      i_rst_n = 1'b1;
      step();
      i_ready = 1'b1;
      push(8'h00, 8'h00, 8'h00);
      chk("rm_nx",   o_x, 0);
      chk("rm_ny",   o_y, 0);
      chk("rm_nsof", o_sof, 1);
      step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rgb_pixel_framer.md
Name: rgb_pixel_framer

Overview:
Downstream stage of the Ethernet RGB16 payload parser. Takes its per-pixel 3-channel strobe (R, G and B, 8 bits each, with a single valid) and optionally expands the zero-padded 5/6-bit channels to full 8-bit range. Tags each pixel with frame coordinates and start-of-frame, end-of-line and end-of-frame flags. Buffers pixels in a FIFO and presents them to the dehazing pipeline over a valid/ready handshake. The parser cannot be back-pressured, so overflow drops pixels, keeps the frame geometry intact and raises a sticky flag.

Parameters:
WIDTH, 640, pixels per line (>=2)
HEIGHT, 480, lines per frame (>=2)
X_W, 11, x coordinate width, 2^X_W >= WIDTH
Y_W, 10, y coordinate width, 2^Y_W >= HEIGHT
DEPTH, 16, FIFO entries, power of two, >=2
EXPAND, 1, 1: replicate MSBs into the low bits; 0: pass channels unchanged

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_sync  in  1  one-cycle resync; next pixel is (0,0)
i_clr_ovf  in  1  clears o_overflow
i_valid  in  1  pixel strobe from the parser
i_channel_R  in  8  red, {r5,3'b0}
i_channel_G  in  8  green, {g6,2'b0}
i_channel_B  in  8  blue, {b5,3'b0}
o_valid  out  1  output pixel available
i_ready  in  1  downstream accepts
o_data  out  24  {R,G,B}
o_x  out  X_W  pixel column
o_y  out  Y_W  pixel row
o_sof  out  1  pixel is (0,0)
o_eol  out  1  x == WIDTH-1
o_eof  out  1  x == WIDTH-1 and y == HEIGHT-1
o_overflow  out  1  sticky, set when a pixel is dropped
o_frame_cnt  out  8  completed frames, wraps at 255 -> 0
o_level  out  $clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset: all outputs 0, coordinate counters at (0,0), FIFO empty. Reset mid-frame discards all buffered pixels.
- Expansion (EXPAND=1):
  - R8 = {R[7:3],R[7:5]}
  - G8 = {G[7:2],G[7:6]}
  - B8 = {B[7:3],B[7:5]}
- Expansion (EXPAND=0): channels pass through unchanged.
- Tagging: on i_valid, the pixel takes the current (x,y); the flags are computed combinationally from (x,y).
- Counter advance on every i_valid cycle:
  - x<WIDTH-1: x+1
  - otherwise: x=0; y+1, or y=0 with o_frame_cnt+1 when y==HEIGHT-1
- Push: the 24-bit data, x, y and 3 flags are written as one FIFO entry.
- Full FIFO, no pop in the same cycle: the pixel is dropped, counters still advance, o_overflow=1 next cycle.
- Full FIFO with a pop in the same cycle: the push is accepted and the level is unchanged.
- Sync:
  - i_sync without i_valid: counters = (0,0) next cycle.
  - i_sync with i_valid: the pixel is tagged (0,0) with o_sof=1, counters = (1,0).
  - o_frame_cnt is not incremented by sync.
- Overflow flag: cleared by i_clr_ovf. If a drop and i_clr_ovf occur in the same cycle, set wins.
- Output side: first-word-fall-through.
  - o_valid = FIFO non-empty; o_data, o_x, o_y and the flags show the head entry.
  - A pop occurs when o_valid && i_ready.
  - While o_valid && !i_ready, all outputs hold stable.
- Latency: a pixel pushed into an empty FIFO in cycle N is valid on the outputs in cycle N+1.
- Throughput: one pixel per clock at sustained input and output rates.
- o_level: registered count of FIFO entries; equals DEPTH when full.
- Pointers: wrap modulo DEPTH. Full/empty are derived from an extra pointer MSB.

Decomposition:
- Package pixel_pkg:
  - typedef rgb24_t (packed R,G,B bytes)
  - typedef pix_entry_t (rgb24_t, x, y, sof, eol, eof)
  - function expand565
- Sub-module sync_fifo_fwft:
  - parameters W, DEPTH
  - ports push/din/full, pop/dout/empty, level
  - reused elsewhere for line buffering
- Top level holds the expansion logic, coordinate counters, sync handling and overflow flag.

Test Plan:
- Reset, then one pixel R=0xF8,G=0xFC,B=0xF8, EXPAND=1, i_ready=1 -> next cycle o_data=0xFFFFFF, o_x=0, o_y=0, o_sof=1, o_level=1 then 0.
- WIDTH=4, HEIGHT=2, 8 consecutive pixels with i_ready=1:
  - o_eol on x=3 pixels; o_eof on pixel 8 only.
  - o_frame_cnt=1; the 9th pixel has o_sof=1.
- i_ready=0, DEPTH=16, 20 pixels -> o_level=16, o_overflow=1, 4 pixels dropped; then i_ready=1 -> 16 pixels out with x=0..15, and the next input is tagged x=20 (geometry preserved).
- i_sync together with i_valid at x=5 -> that pixel is (0,0) with o_sof=1, the following pixel is x=1; o_frame_cnt unchanged.
- FIFO full, then push and pop in the same cycle -> o_level stays 16, no overflow.
- i_clr_ovf and a drop in the same cycle -> o_overflow stays 1.
- Assert i_rst_n low mid-frame with o_level=7 -> all outputs 0, and the next pixel is tagged (0,0).
